// File: rtl/ssp_tx_shifter.sv
// -----------------------------------------------------------------------------
// ssp_tx_shifter
//   Transmit serializer for the SSP in TI synchronous serial frame format.
//   Each frame is a one-bit-period SSPFSSOUT sync pulse followed by DATA_WIDTH
//   data bits. One word is taken from the transmit FIFO head per frame.
//
//   Handshake with the FIFO: i_TX_VALID=1 means i_TXDATA holds a valid head
//   word. The word is consumed only on a bit-clock rise at a frame boundary,
//   and the consumption is signalled by a one-cycle o_REQ pulse. The FIFO pops
//   a few cycles later. The head is not sampled again until the next frame
//   boundary, so a stale head word is never reloaded.
//
//   Configuration macro: SSP_TX_LSB_FIRST_EN
//     defined     : LSB first (shift right, SSPTXD = shreg[0])
//     not defined : MSB first (shift left, SSPTXD = shreg[DATA_WIDTH-1])
//
// Ports
//   i_PCLK       system clock, all flops on posedge
//   i_CLEAR_B    synchronous active-low reset
//   i_TXDATA     FIFO head word
//   i_TX_VALID   FIFO not empty
//   o_REQ        one-cycle pop request per loaded word
//   o_SSPCLKOUT  free-running serial clock, 50% duty, half period CLK_DIV
//   o_SSPFSSOUT  frame sync pulse, one bit period wide
//   o_SSPTXD     serial data, changes on SSPCLKOUT rise
//   o_SSPOE_B    active-low pad output enable, low during SYNC and SHIFT
//   o_TX_BUSY    high whenever the FSM is not IDLE
//   o_STATE_DBG  current FSM state (debug observation)
// -----------------------------------------------------------------------------
module ssp_tx_shifter #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 1
) (
   input  logic                  i_PCLK,
   input  logic                  i_CLEAR_B,
   input  logic [DATA_WIDTH-1:0] i_TXDATA,
   input  logic                  i_TX_VALID,
   output logic                  o_REQ,
   output logic                  o_SSPCLKOUT,
   output logic                  o_SSPFSSOUT,
   output logic                  o_SSPTXD,
   output logic                  o_SSPOE_B,
   output logic                  o_TX_BUSY,
   output logic [1:0]            o_STATE_DBG
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SYNC  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;

   logic [1:0]            state_q,   state_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic                  sspclk_q,  sspclk_d;
   logic                  fss_q,     fss_d;
   logic                  txd_q,     txd_d;
   logic                  oe_b_q,    oe_b_d;
   logic                  req_q,     req_d;
   logic [DATA_WIDTH-1:0] shreg_q,   shreg_d;
   logic [CNT_W-1:0]      bitcnt_q,  bitcnt_d;

   logic                  div_wrap;
   logic                  rise_tick;
   logic                  load;
   logic                  out_bit;
   logic [DATA_WIDTH-1:0] shifted;

   // Bit order selection: only the tapped bit and shift direction change.
   always_comb begin
`ifdef SSP_TX_LSB_FIRST_EN
      out_bit = shreg_q[0];
      shifted = shreg_q >> 1;
`else
      out_bit = shreg_q[DATA_WIDTH-1];
      shifted = shreg_q << 1;
`endif
   end

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      sspclk_d  = sspclk_q;
      fss_d     = fss_q;
      txd_d     = txd_q;
      oe_b_d    = oe_b_q;
      req_d     = 1'b0;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      load      = 1'b0;

      // Free-running divider; the serial clock toggles on every wrap.
      div_wrap = (div_cnt_q == DIV_LAST);
      if (div_wrap) begin
         div_cnt_d = '0;
         sspclk_d  = ~sspclk_q;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end

      // Everything else moves only on the edge where SSPCLKOUT goes 0->1.
      rise_tick = div_wrap & ~sspclk_q;

      if (rise_tick) begin
         case (state_q)
            IDLE: begin
               txd_d  = 1'b0;
               fss_d  = 1'b0;
               oe_b_d = 1'b1;
               load   = i_TX_VALID;
            end
            SYNC: begin
               fss_d    = 1'b0;
               txd_d    = out_bit;
               shreg_d  = shifted;
               bitcnt_d = CNT_LAST;
               state_d  = SHIFT;
            end
            SHIFT: begin
               if (bitcnt_q != '0) begin
                  txd_d    = out_bit;
                  shreg_d  = shifted;
                  bitcnt_d = bitcnt_q - 1'b1;
               end else if (i_TX_VALID) begin
                  // Back-to-back: next sync pulse follows the last bit directly.
                  load = 1'b1;
               end else begin
                  txd_d   = 1'b0;
                  oe_b_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (load) begin
            shreg_d = i_TXDATA;
            req_d   = 1'b1;
            fss_d   = 1'b1;
            oe_b_d  = 1'b0;
            txd_d   = 1'b0;
            state_d = SYNC;
         end
      end
   end

   always_ff @(posedge i_PCLK) begin
      if (!i_CLEAR_B) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         sspclk_q  <= 1'b0;
         fss_q     <= 1'b0;
         txd_q     <= 1'b0;
         oe_b_q    <= 1'b1;
         req_q     <= 1'b0;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         sspclk_q  <= sspclk_d;
         fss_q     <= fss_d;
         txd_q     <= txd_d;
         oe_b_q    <= oe_b_d;
         req_q     <= req_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
      end
   end

   assign o_REQ       = req_q;
   assign o_SSPCLKOUT = sspclk_q;
   assign o_SSPFSSOUT = fss_q;
   assign o_SSPTXD    = txd_q;
   assign o_SSPOE_B   = oe_b_q;
   assign o_TX_BUSY   = (state_q != IDLE);
   assign o_STATE_DBG = state_q;

endmodule
